fifo_mem_ctrl: RTL and testbench
================================

// Module: fifo_mem_ctrl
// PURPOSE
// - Single-clock controller for the FIFO memory: owns write/read pointers, full/empty/count.
// - Shares the memory's one write port among NUM_REQ push requesters by round-robin arbitration.
// - Drives the memory's wr_addrs/data_in/rd_addrs; both memory clocks tie to wr_clk.
// - Memory writes unconditionally every edge, so the controller always drives a benign write.
// PARAMETERS
// - DATA_WIDTH  8  width of one FIFO entry
// - ADD_WIDTH   3  memory address width; depth = 2**ADD_WIDTH
// - NUM_REQ     4  number of push requesters (>=2)
// PORTS
// - wr_clk        in   1                   single clock for controller and memory
// - wr_rst        in   1                   synchronous, active-high reset
// - req           in   NUM_REQ             push request per requester; held until granted
// - req_data      in   NUM_REQ*DATA_WIDTH  push data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
// - gnt           out  NUM_REQ             one-hot grant, combinational; push accepted at edge when req[i]&gnt[i]
// - pop           in   1                   read request; accepted when !empty
// - rd_valid      out  1                   memory data_out holds popped entry this cycle
// - mem_wr_addrs  out  ADD_WIDTH           to memory wr_addrs
// - mem_data_in   out  DATA_WIDTH          to memory data_in
// - mem_rd_addrs  out  ADD_WIDTH           to memory rd_addrs (= rd_ptr)
// - full          out  1                   count == 2**ADD_WIDTH
// - empty         out  1                   count == 0
// - count         out  ADD_WIDTH+1         occupied entries
// BEHAVIOUR
// - Reset (sync, high): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rr_ptr=0,
//   last_addr=0, last_data=0, gnt=0. Memory reset must be asserted in the same cycle.
// - Pointers ADD_WIDTH wide, wrap 2**ADD_WIDTH-1 -> 0 naturally; count separate, ADD_WIDTH+1 bits.
// - Arbitration: when !full, gnt = first req at or after rr_ptr (cyclic); else gnt=0.
//   On accepted push from i: rr_ptr <= (i+1) mod NUM_REQ. No accept -> rr_ptr holds.
// - Push cycle: mem_wr_addrs=wr_ptr, mem_data_in=req_data[i]; at edge wr_ptr++, last_addr<=wr_ptr,
//   last_data<=req_data[i].
// - Idle cycle: park on last write: mem_wr_addrs=last_addr, mem_data_in=last_data (rewrites same
//   value into newest or already-freed slot; never disturbs a valid entry, including when full).
// - Pop: accepted iff pop & !empty; mem_rd_addrs=rd_ptr always; at edge rd_ptr++, memory latches
//   entry; rd_valid=1 next cycle for exactly one cycle per accepted pop. Pop while empty ignored.
// - Latency: push accepted at edge N -> poppable at edge N+1 -> data valid cycle after that pop.
// - Push+pop same edge: both accepted if !full & !empty; count unchanged.
// - Full uses pre-edge count: pop while full frees a slot but gnt stays 0 that cycle.
// - Empty: pop ignored; a same-cycle push is accepted, count 0->1.
// - Reset mid-operation: all state to reset values next edge; in-flight rd_valid cleared;
//   buffered entries discarded.
// CONFIGURATION
// - FIFO_CTRL_ERR_EN defined: adds outputs err_overflow, err_underflow (1 bit each) and input
//   err_clr. err_overflow sets sticky when any req high while full; err_underflow sets when
//   pop high while empty; err_clr (or wr_rst) clears both next edge; set wins over same-cycle clear.
// - Not defined: ports and logic absent; overflow/underflow silently ignored as above.
// TESTING
// - Reset, then req=4'b0001 data 0x11 -> gnt=0001, count=1, mem write addr0=0x11; pop -> rd_valid next, data_out=0x11.
// - req=4'b1111 held, data 0xA0..0xA3 -> grants 0,1,2,3,0 in order; 8 pushes -> full=1, gnt=0.
// - Full, idle 5 cycles -> mem_wr_addrs=7, data unchanged; then 8 pops return exact push order.
// - Count=3, push+pop same cycle -> count stays 3; pop while empty -> rd_valid stays 0, pointers hold.
// - Pointer wrap: 12 push/pop pairs -> wr_ptr wraps 7->0, data intact; wr_rst mid-stream -> count=0, rd_valid=0.
// - FIFO_CTRL_ERR_EN: req while full -> err_overflow=1 until err_clr; pop while empty -> err_underflow=1.

Source files
------------

// File: rtl/fifo_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem_ctrl
// Purpose  : Single-clock controller for an external FIFO memory. Owns the
//            write/read pointers and the full/empty/count status. Shares the
//            memory's single write port among NUM_REQ push requesters using
//            round-robin arbitration. Drives the memory write address/data
//            and read address. The memory writes on every edge, so when no
//            push is accepted the controller re-drives the last write
//            (same address, same data), which never disturbs a valid entry.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: FIFO_CTRL_ERR_EN
//   When defined, adds the sticky error flags err_overflow / err_underflow
//   and the clear input err_clr.
// ----------------------------------------------------------------------------
// Ports
//   wr_clk        in   1                   clock for controller and memory
//   wr_rst        in   1                   synchronous active-high reset
//   req           in   NUM_REQ             push request per requester
//   req_data      in   NUM_REQ*DATA_WIDTH  push data, requester i at slice i
//   gnt           out  NUM_REQ             one-hot combinational grant
//   pop           in   1                   read request (ignored when empty)
//   rd_valid      out  1                   memory data_out holds popped entry
//   mem_wr_addrs  out  ADD_WIDTH           memory write address
//   mem_data_in   out  DATA_WIDTH          memory write data
//   mem_rd_addrs  out  ADD_WIDTH           memory read address (= rd_ptr)
//   full          out  1                   count == 2**ADD_WIDTH
//   empty         out  1                   count == 0
//   count         out  ADD_WIDTH+1         occupied entries
//   err_clr       in   1                   (FIFO_CTRL_ERR_EN) clear errors
//   err_overflow  out  1                   (FIFO_CTRL_ERR_EN) req while full
//   err_underflow out  1                   (FIFO_CTRL_ERR_EN) pop while empty
// ============================================================================
module fifo_mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 3,
  parameter int NUM_REQ    = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          pop,
  output logic                          rd_valid,
  output logic [ADD_WIDTH-1:0]          mem_wr_addrs,
  output logic [DATA_WIDTH-1:0]         mem_data_in,
  output logic [ADD_WIDTH-1:0]          mem_rd_addrs,
  output logic                          full,
  output logic                          empty,
  output logic [ADD_WIDTH:0]            count
`ifdef FIFO_CTRL_ERR_EN
  ,
  input  logic                          err_clr,
  output logic                          err_overflow,
  output logic                          err_underflow
`endif
);

  localparam int                   c_RRW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_RRW:0]       c_NREQ  = (c_RRW+1)'(NUM_REQ);
  localparam logic [ADD_WIDTH:0]   c_DEPTH = (ADD_WIDTH+1)'(2**ADD_WIDTH);
  localparam logic [ADD_WIDTH:0]   c_ONE   = (ADD_WIDTH+1)'(1);
  localparam logic [ADD_WIDTH-1:0] c_PONE  = ADD_WIDTH'(1);

  // Registered state
  logic [ADD_WIDTH-1:0]  r_wr_ptr;
  logic [ADD_WIDTH-1:0]  r_rd_ptr;
  logic [ADD_WIDTH:0]    r_count;
  logic                  r_rd_valid;
  logic [c_RRW-1:0]      r_rr_ptr;
  logic [ADD_WIDTH-1:0]  r_last_addr;
  logic [DATA_WIDTH-1:0] r_last_data;

  // Combinational signals
  logic                  w_full;
  logic                  w_empty;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [c_RRW-1:0]      w_gnt_idx;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;

  // Reduce a value in [0, 2*NUM_REQ-2] modulo NUM_REQ.
  function automatic logic [c_RRW-1:0] f_wrap(input logic [c_RRW:0] v);
    logic [c_RRW:0] t;
    t = (v >= c_NREQ) ? (v - c_NREQ) : v;
    return t[c_RRW-1:0];
  endfunction

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  // Round-robin search: first requester at or after r_rr_ptr, cyclically.
  // Full is judged on the pre-edge count, so a pop while full does not open
  // the write port in the same cycle.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_push    = 1'b0;
    if (!w_full && !wr_rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_push && req[f_wrap({1'b0, r_rr_ptr} + k[c_RRW:0])]) begin
          w_push    = 1'b1;
          w_gnt_idx = f_wrap({1'b0, r_rr_ptr} + k[c_RRW:0]);
        end
      end
      if (w_push) begin
        w_gnt[w_gnt_idx] = 1'b1;
      end
    end
  end

  assign w_pop       = pop && !w_empty && !wr_rst;
  assign w_push_data = req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  // With no push, park the write port on the last write: it rewrites the
  // same value into either the newest entry or an already-freed slot.
  assign mem_wr_addrs = w_push ? r_wr_ptr    : r_last_addr;
  assign mem_data_in  = w_push ? w_push_data : r_last_data;
  assign mem_rd_addrs = r_rd_ptr;

  assign gnt      = w_gnt;
  assign rd_valid = r_rd_valid;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_rr_ptr    <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + c_PONE;
        r_last_addr <= r_wr_ptr;
        r_last_data <= w_push_data;
        r_rr_ptr    <= f_wrap({1'b0, w_gnt_idx} + (c_RRW+1)'(1));
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic r_err_ovf;
  logic r_err_udf;

  // Sticky flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if ((|req) && w_full) begin
        r_err_ovf <= 1'b1;
      end else if (err_clr) begin
        r_err_ovf <= 1'b0;
      end
      if (pop && w_empty) begin
        r_err_udf <= 1'b1;
      end else if (err_clr) begin
        r_err_udf <= 1'b0;
      end
    end
  end

  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_udf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_mem_ctrl
// Purpose  : Directed self-checking bench for fifo_mem_ctrl with a simple
//            behavioural model of the external memory (write every edge,
//            registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_mem_ctrl;

  localparam int c_DW = 8;
  localparam int c_AW = 3;
  localparam int c_NR = 4;

  logic                 clk;
  logic                 rst;
  logic [c_NR-1:0]      req;
  logic [c_NR*c_DW-1:0] req_data;
  logic [c_NR-1:0]      gnt;
  logic                 pop;
  logic                 rd_valid;
  logic [c_AW-1:0]      wa;
  logic [c_DW-1:0]      din;
  logic [c_AW-1:0]      ra;
  logic                 full;
  logic                 empty;
  logic [c_AW:0]        count;
`ifdef FIFO_CTRL_ERR_EN
  logic                 err_clr;
  logic                 err_ovf;
  logic                 err_udf;
`endif

  // Memory model
  logic [c_DW-1:0] mem [2**c_AW];
  logic [c_DW-1:0] data_out;

  int n_chk;
  int n_fail;

  fifo_mem_ctrl #(
    .DATA_WIDTH (c_DW),
    .ADD_WIDTH  (c_AW),
    .NUM_REQ    (c_NR)
  ) dut (
    .wr_clk       (clk),
    .wr_rst       (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .pop          (pop),
    .rd_valid     (rd_valid),
    .mem_wr_addrs (wa),
    .mem_data_in  (din),
    .mem_rd_addrs (ra),
    .full         (full),
    .empty        (empty),
    .count        (count)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .err_clr      (err_clr),
    .err_overflow (err_ovf),
    .err_underflow(err_udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem[wa]  <= din;
    data_out <= mem[ra];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    pop = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    req_data = '0;
`ifdef FIFO_CTRL_ERR_EN
    err_clr  = 1'b0;
`endif
    // ---------------- reset state
    do_reset();
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rd_addr", 32'(ra), 0);
    chk("rst_wr_addr", 32'(wa), 0);

    // ---------------- single push / pop
    req = 4'b0001;
    req_data[7:0] = 8'h11;
    #2;
    chk("p1_gnt", 32'(gnt), 32'h1);
    chk("p1_wa", 32'(wa), 0);
    chk("p1_din", 32'(din), 32'h11);
    tick();
    req = '0;
    chk("p1_count", 32'(count), 1);
    chk("p1_empty", 32'(empty), 0);
    chk("p1_mem0", 32'(mem[0]), 32'h11);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("p1_rd_valid", 32'(rd_valid), 1);
    chk("p1_data_out", 32'(data_out), 32'h11);
    chk("p1_count0", 32'(count), 0);
    tick();
    chk("p1_rd_valid_drop", 32'(rd_valid), 0);

    // ---------------- round robin fill to full
    do_reset();
    req = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      chk("rr_wa", 32'(wa), 32'(k));
      tick();
    end
    #2;
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    chk("fill_gnt0", 32'(gnt), 0);

    // ---------------- idle while full parks on last write
    req = '0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("park_wa", 32'(wa), 7);
      chk("park_din", 32'(din), 32'hA3);
      tick();
    end

    // ---------------- drain in push order; pop while full does not grant
    pop = 1'b1;
    req = 4'b0001;
    #2;
    chk("full_pop_gnt", 32'(gnt), 0);
    req = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(data_out), 32'(8'hA0 + (k % 4)));
    end
    pop = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    tick();
    chk("drain_valid_drop", 32'(rd_valid), 0);

    // ---------------- simultaneous push + pop at count 3
    req = 4'b0001;
    req_data[7:0] = 8'h31; tick();
    req_data[7:0] = 8'h32; tick();
    req_data[7:0] = 8'h33; tick();
    req = '0;
    chk("c3_count", 32'(count), 3);
    req = 4'b0001;
    req_data[7:0] = 8'h34;
    pop = 1'b1;
    tick();
    req = '0;
    chk("pp_count", 32'(count), 3);
    chk("pp_valid", 32'(rd_valid), 1);
    chk("pp_data", 32'(data_out), 32'h31);
    tick(); chk("pp_d2", 32'(data_out), 32'h32);
    tick(); chk("pp_d3", 32'(data_out), 32'h33);
    tick(); chk("pp_d4", 32'(data_out), 32'h34);
    chk("pp_empty", 32'(empty), 1);
    // pop while empty
    tick();
    pop = 1'b0;
    chk("ue_valid", 32'(rd_valid), 0);
    chk("ue_count", 32'(count), 0);
    chk("ue_rd_addr", 32'(ra), 4);

    // ---------------- pointer wrap with push/pop pairs
    for (int k = 0; k < 12; k++) begin
      req = 4'b0001;
      req_data[7:0] = 8'(8'h50 + k);
      pop = (k > 0);
      #2;
      chk("wrap_wa", 32'(wa), 32'((4 + k) % 8));
      tick();
      if (k > 0) begin
        chk("wrap_valid", 32'(rd_valid), 1);
        chk("wrap_data", 32'(data_out), 32'(8'h50 + k - 1));
      end
    end
    req = '0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("wrap_last", 32'(data_out), 32'h5B);
    chk("wrap_count", 32'(count), 0);

    // ---------------- reset mid-stream
    req = 4'b0001;
    req_data[7:0] = 8'h61; tick();
    req_data[7:0] = 8'h62; tick();
    req = '0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("mr_valid_pre", 32'(rd_valid), 1);
    chk("mr_data_pre", 32'(data_out), 32'h61);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(rd_valid), 0);
    chk("mr_count", 32'(count), 0);
    chk("mr_empty", 32'(empty), 1);
    chk("mr_rd_addr", 32'(ra), 0);

`ifdef FIFO_CTRL_ERR_EN
    // ---------------- sticky error flags
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) tick();
    chk("err_ovf_pre", 32'(err_ovf), 0);
    tick();
    req = '0;
    chk("err_ovf_set", 32'(err_ovf), 1);
    tick();
    chk("err_ovf_hold", 32'(err_ovf), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_ovf_clr", 32'(err_ovf), 0);
    do_reset();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("err_udf_set", 32'(err_udf), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
